tristate_bus_arbiter: RTL

- Parametrised successor to the single-bit tri-state buffer.
- Lets N requesters share one WIDTH-bit tri-state bus.
- Round-robin arbitration, registered one-hot grant, bounded tenure, and a mandatory all-Z turnaround between bus owners.
- Sits between multiple drivers (e.g. decoder-selected sources) and any shared bus net, so no two drivers ever contend.

---
 rtl/tristate_bus_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: N requesters share one WIDTH-bit tri-state bus.
// Round-robin arbitration, registered one-hot grant, bounded tenure and a
// mandatory all-Z turnaround of TURN_CYC cycles between owners.
// Optional feature macro: BUS_KEEPER_EN. When defined, bus_y holds the last
// driven value instead of floating while no channel owns the bus.

// Per-lane data gate: passes the lane's din slice only while it holds the grant.
module tba_lane #(
  parameter int WIDTH = 8
) (
  input  logic             gnt_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dat_o
);
  assign dat_o = din_i & {WIDTH{gnt_i}};
endmodule

module tristate_bus_arbiter #(
  parameter int N        = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16,
  parameter int TURN_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] din,
  output logic [N-1:0]       gnt,
  output wire  [WIDTH-1:0]   bus_y,
  output logic               oe,
  output logic               busy
);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int TW = $clog2(TURN_CYC + 1);
  localparam int PW = $clog2(N);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);
  localparam logic [N-1:0]  ONE       = N'(1);
  localparam logic [PW-1:0] LAST_CH   = PW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q,   gnt_d;
  logic            oe_q,    oe_d;
  logic [HW-1:0]   hold_q,  hold_d;
  logic [TW-1:0]   tcnt_q,  tcnt_d;
  logic [PW-1:0]   ptr_q,   ptr_d;

  logic            win_vld;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand;
  logic            arb_go;
  logic            own_req;
  logic            oth_req;

  logic [N-1:0][WIDTH-1:0] lane_dat;
  logic [WIDTH-1:0]        drv;

  // Lane gates: only the granted lane contributes a non-zero slice.
  for (genvar g = 0; g < N; g++) begin : g_lane
    tba_lane #(.WIDTH(WIDTH)) u_lane (
      .gnt_i (gnt_q[g]),
      .din_i (din[g*WIDTH +: WIDTH]),
      .dat_o (lane_dat[g])
    );
  end

  // OR-merge of the gated lanes; the grant is one-hot so this is a mux.
  always_comb begin
    drv = '0;
    for (int i = 0; i < N; i++) drv = drv | lane_dat[i];
  end

  // Round-robin pick: scan down so the channel closest above the pointer wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr_q) + k) % N);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign own_req = |(req & gnt_q);
  assign oth_req = |(req & ~gnt_q);

  // Next-state: tenure bookkeeping in DRIVE, turnaround count in TURN,
  // shared arbitration step for IDLE and the last TURN cycle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    oe_d    = oe_q;
    hold_d  = hold_q;
    tcnt_d  = tcnt_q;
    ptr_d   = ptr_q;
    arb_go  = 1'b0;
    case (state_q)
      S_IDLE: arb_go = 1'b1;
      S_DRIVE: begin
        if (!own_req || (hold_q == HOLD_LAST && oth_req)) begin
          // Owner released, or forced rotation because others wait.
          state_d = S_TURN;
          gnt_d   = '0;
          oe_d    = 1'b0;
          hold_d  = '0;
          tcnt_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          // Sole requester keeps the bus; restart the tenure count.
          hold_d = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_TURN: begin
        if (tcnt_q == TURN_LAST) arb_go = 1'b1;
        else                     tcnt_d = tcnt_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        oe_d    = 1'b0;
      end
    endcase
    if (arb_go) begin
      tcnt_d = '0;
      if (win_vld) begin
        state_d = S_DRIVE;
        gnt_d   = ONE << win_idx;
        oe_d    = 1'b1;
        hold_d  = '0;
        ptr_d   = (win_idx == LAST_CH) ? '0 : win_idx + 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // State registers; reset clears the grant immediately so the bus floats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      oe_q    <= 1'b0;
      hold_q  <= '0;
      tcnt_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      oe_q    <= oe_d;
      hold_q  <= hold_d;
      tcnt_q  <= tcnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt  = gnt_q;
  assign oe   = oe_q;
  assign busy = (state_q != S_IDLE);

`ifdef BUS_KEEPER_EN
  logic [WIDTH-1:0] keep_q;

  // Keeper follows the driven value so the bus holds it while undriven.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    keep_q <= '0;
    else if (oe_q) keep_q <= drv;
  end

  assign bus_y = oe_q ? drv : keep_q;
`else
  assign bus_y = oe_q ? drv : {WIDTH{1'bz}};
`endif

endmodule
